// File: rtl/memory_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (instruction/data) and the shared RAM.
// slave = arbiter view, master = requester/RAM-side view.
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Instruction/data arbiter for a single shared RAM port; data has priority.
// Optional macro ARB_FAIRNESS_EN adds a data-streak counter that forces an instruction grant.
module memory_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input logic               CLK,
    input logic               RST,
    memory_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    state_t state;
    state_t state_next;
    logic   dreq;
    logic   force_iacc;

    if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15) begin : g_bad_param
        $error("MAX_DSTREAK must be in 1..15");
    end

    assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_FAIRNESS_EN
    logic       i_done;
    logic       d_done;
    logic [3:0] dstreak;

    assign i_done = (state == IACC) && bus.iREN && bus.ramready;
    assign d_done = (state == DACC) && dreq && bus.ramready;

    // Counts data completions that happened while an instruction fetch was waiting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dstreak <= '0;
        end else if (i_done) begin
            dstreak <= '0;
        end else if (d_done) begin
            if (!bus.iREN)
                dstreak <= '0;
            else if (dstreak != '1)
                dstreak <= dstreak + 4'd1;
        end
    end

    assign force_iacc = bus.iREN && (dstreak >= 4'(MAX_DSTREAK));
`else
    assign force_iacc = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (dreq && !force_iacc)
                    state_next = DACC;
                else if (bus.iREN)
                    state_next = IACC;
            end
            IACC: begin
                if (!bus.iREN || bus.ramready)
                    state_next = IDLE;
            end
            DACC: begin
                if (!dreq || bus.ramready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state)
            IACC: begin
                // Following iREN lets an aborted fetch drop the enable in the same cycle.
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
            end
            DACC: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            default: ;
        endcase
        bus.iwait = bus.iREN & ~((state == IACC) & bus.ramready);
        bus.dwait = dreq & ~((state == DACC) & bus.ramready);
        bus.iload = bus.ramload;
        bus.dload = bus.ramload;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, streak sequence,
// and randomized traffic checked against an ownership-based reference model.
module tb_memory_arbiter;
    localparam logic [31:0] IADDR = 32'h0000_2000;
    localparam logic [31:0] DST   = 32'hDEAD_BEEF;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int MAXS = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    memory_arbiter_if bus ();

    memory_arbiter #(.MAX_DSTREAK(MAXS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst, iren, dren, dwen, rdy;
        logic [31:0] daddr;
        logic        ex_iwait, ex_dwait, ex_ren, ex_wen;
        logic [31:0] ex_addr, ex_store;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t v(input logic [4:0] in, input logic [31:0] da,
                               input logic [3:0] ex, input logic [31:0] ea,
                               input logic [31:0] es);
        vec_t r;
        {r.rst, r.iren, r.dren, r.dwen, r.rdy} = in;
        r.daddr = da;
        {r.ex_iwait, r.ex_dwait, r.ex_ren, r.ex_wen} = ex;
        r.ex_addr  = ea;
        r.ex_store = es;
        return r;
    endfunction

    function automatic logic [131:0] actual();
        return {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN,
                bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
    endfunction

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iren, input logic dren, input logic dwen,
                         input logic rdy, input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input logic [31:0] rl);
        RST          = rst;
        bus.iREN     = iren;
        bus.dREN     = dren;
        bus.dWEN     = dwen;
        bus.ramready = rdy;
        bus.iaddr    = ia;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramload  = rl;
    endtask

    // reference model: who currently owns the RAM (0 none, 1 instruction, 2 data)
    int owner  = 0;
    int streak = 0;

    task automatic model_cycle(input string name);
        logic        dreq, own_i, own_d;
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        bit          forced;
        if (RST) begin
            owner  = 0;
            streak = 0;
        end
        dreq  = bus.dREN | bus.dWEN;
        own_i = (owner == 1);
        own_d = (owner == 2);
        e_ren   = own_i ? bus.iREN : (own_d ? bus.dREN : 1'b0);
        e_wen   = own_d ? bus.dWEN : 1'b0;
        e_addr  = own_i ? bus.iaddr : (own_d ? bus.daddr : 32'h0);
        e_store = own_d ? bus.dstore : 32'h0;
        e_iw    = bus.iREN && !(own_i && bus.ramready);
        e_dw    = dreq && !(own_d && bus.ramready);
        check(name, actual(), {e_iw, e_dw, e_ren, e_wen, e_addr, e_store, bus.ramload, bus.ramload});
        if (RST) return;
        if (owner == 0) begin
            forced = FAIR && bus.iREN && (streak >= MAXS);
            if (dreq && !forced) owner = 2;
            else if (bus.iREN)   owner = 1;
        end else if (owner == 1) begin
            if (bus.iREN && bus.ramready) streak = 0;
            if (!bus.iREN || bus.ramready) owner = 0;
        end else begin
            if (dreq && bus.ramready) streak = bus.iREN ? ((streak < 15) ? streak + 1 : 15) : 0;
            if (!dreq || bus.ramready) owner = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    initial begin
        string       evs;
        int          n_i, n_d;
        logic        i_req, d_req, d_wr;
        string       pat;
        logic [7:0]  ch;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        // ---------------- directed vector table ----------------
        tbl[0]  = v(5'b11000, 32'h0,   4'b1000, 32'h0,   32'h0);
        tbl[1]  = v(5'b01001, 32'h0,   4'b1000, 32'h0,   32'h0);
        tbl[2]  = v(5'b01001, 32'h0,   4'b0010, IADDR,   32'h0);
        tbl[3]  = v(5'b01101, 32'h100, 4'b1100, 32'h0,   32'h0);
        tbl[4]  = v(5'b01101, 32'h100, 4'b1010, 32'h100, DST);
        tbl[5]  = v(5'b01001, 32'h0,   4'b1000, 32'h0,   32'h0);
        tbl[6]  = v(5'b01001, 32'h0,   4'b0010, IADDR,   32'h0);
        tbl[7]  = v(5'b00000, 32'h0,   4'b0000, 32'h0,   32'h0);
        tbl[8]  = v(5'b00010, 32'h40,  4'b0100, 32'h0,   32'h0);
        tbl[9]  = v(5'b00010, 32'h40,  4'b0101, 32'h40,  DST);
        tbl[10] = v(5'b00010, 32'h40,  4'b0101, 32'h40,  DST);
        tbl[11] = v(5'b00010, 32'h40,  4'b0101, 32'h40,  DST);
        tbl[12] = v(5'b00011, 32'h40,  4'b0001, 32'h40,  DST);
        tbl[13] = v(5'b00000, 32'h0,   4'b0000, 32'h0,   32'h0);
        tbl[14] = v(5'b01000, 32'h0,   4'b1000, 32'h0,   32'h0);
        tbl[15] = v(5'b01000, 32'h0,   4'b1010, IADDR,   32'h0);
        tbl[16] = v(5'b00000, 32'h0,   4'b0000, IADDR,   32'h0);
        tbl[17] = v(5'b00001, 32'h0,   4'b0000, 32'h0,   32'h0);
        tbl[18] = v(5'b00001, 32'h0,   4'b0000, 32'h0,   32'h0);
        tbl[19] = v(5'b00100, 32'h80,  4'b0100, 32'h0,   32'h0);
        tbl[20] = v(5'b00100, 32'h80,  4'b0110, 32'h80,  DST);
        tbl[21] = v(5'b10101, 32'h80,  4'b0100, 32'h0,   32'h0);
        tbl[22] = v(5'b00101, 32'h80,  4'b0100, 32'h0,   32'h0);
        tbl[23] = v(5'b00101, 32'h80,  4'b0010, 32'h80,  DST);
        tbl[24] = v(5'b00000, 32'h0,   4'b0000, 32'h0,   32'h0);

        @(posedge CLK);
        for (int i = 0; i < 25; i++) begin
            logic [31:0] rl;
            @(posedge CLK); #1;
            rl = 32'hA500_0000 | 32'(i);
            drive(tbl[i].rst, tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].rdy,
                  IADDR, tbl[i].daddr, DST, rl);
            @(negedge CLK);
            check($sformatf("vec%0d", i), actual(),
                  {tbl[i].ex_iwait, tbl[i].ex_dwait, tbl[i].ex_ren, tbl[i].ex_wen,
                   tbl[i].ex_addr, tbl[i].ex_store, rl, rl});
        end

        // ---------------- sustained contention (streak behaviour) ----------------
        do_reset();
        evs = "";
        n_i = 0;
        n_d = 0;
        for (int c = 0; c < 60; c++) begin
            if (c != 0) begin
                @(posedge CLK); #1;
            end
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, IADDR, 32'h100, DST, 32'h1234_5678);
            @(negedge CLK);
            if (!bus.dwait) begin evs = {evs, "D"}; n_d++; end
            if (!bus.iwait) begin evs = {evs, "I"}; n_i++; end
        end
        if (FAIR) begin
            pat = "DDDDI";
            check("streak_count", 132'(evs.len()), 132'(30));
            for (int k = 0; k < 25; k++) begin
                ch = (k < evs.len()) ? evs[k] : 8'h3F;
                check($sformatf("streak_ev%0d", k), 132'(ch), 132'(pat[k % 5]));
            end
        end else begin
            check("starve_inst", 132'(n_i), 132'(0));
            check("starve_data", 132'(n_d), 132'(30));
        end

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        owner  = 0;
        streak = 0;
        i_req  = 1'b0;
        d_req  = 1'b0;
        d_wr   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic rst_r;
            @(posedge CLK); #1;
            rst_r = ($urandom_range(0, 99) == 0);
            if (i_req) begin
                if ($urandom_range(0, 29) == 0) i_req = 1'b0;
            end else begin
                i_req = ($urandom_range(0, 1) == 1);
            end
            if (d_req) begin
                if ($urandom_range(0, 29) == 0) d_req = 1'b0;
            end else begin
                d_req = ($urandom_range(0, 1) == 1);
                d_wr  = ($urandom_range(0, 1) == 1);
            end
            drive(rst_r, i_req, d_req & ~d_wr, d_req & d_wr, 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom, $urandom);
            @(negedge CLK);
            model_cycle($sformatf("rand%0d", c));
            if (!RST && bus.iREN && owner == 0 && bus.ramready) i_req = ($urandom_range(0, 1) == 1);
            if (!RST && (bus.dREN | bus.dWEN) && owner == 0 && bus.ramready) d_req = ($urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
